// File: rtl/likesram_arbiter.sv
// -----------------------------------------------------------------------------
// likesram_arbiter
//
// Shares one sram-like slave port between the instruction and data sram-like
// masters. Only one transaction is in flight at a time: the grant is taken in
// IDLE and stays locked through the address phase (REQ) and the response phase
// (RESP). When both masters request together, the one that did not win the
// previous address handshake goes first, so neither can be starved.
//
// Ports
//   clk, resetn                        clock, asynchronous active-low reset
//   inst_* (req/wr/size/addr/wdata)    instruction master request side
//   inst_addr_ok/data_ok/rdata         instruction master handshakes and data
//   data_*                             same set, for the data master
//   s_req/wr/size/addr/wdata           request forwarded to the slave
//   s_addr_ok/data_ok/rdata            slave handshakes and read data
//   busy                               high whenever a grant is held
// -----------------------------------------------------------------------------
module likesram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction master
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // shared slave
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Owner / last encoding: 0 = instruction master, 1 = data master.
  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_last;
  logic   w_owner_nxt;
  logic   w_last_nxt;

  logic   w_any_req;
  logic   w_winner;
  logic   w_sel;
  logic   w_fwd;
  logic   w_addr_ok;
  logic   w_data_ok;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_fwd        = 1'b0;
    w_addr_ok    = 1'b0;
    w_data_ok    = 1'b0;
    s_req        = 1'b0;
    s_wr         = 1'b0;
    s_size       = '0;
    s_addr       = '0;
    s_wdata      = '0;

    // Requests are masked while reset is asserted so that every output reads
    // zero during reset even if the masters keep their requests raised.
    w_any_req = resetn & (inst_req | data_req);
    // Tie goes to the master that did not take the previous address handshake.
    w_winner  = (inst_req & data_req) ? ~r_last : data_req;
    // Arbitration only happens in IDLE; afterwards the locked owner is used.
    w_sel     = (r_state == ST_IDLE) ? w_winner : r_owner;

    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_fwd       = 1'b1;
          s_req       = 1'b1;
          w_owner_nxt = w_winner;
          if (s_addr_ok) begin
            w_addr_ok   = 1'b1;
            w_last_nxt  = w_winner;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_fwd = 1'b1;
        s_req = r_owner ? data_req : inst_req;
        if (s_addr_ok) begin
          w_addr_ok   = 1'b1;
          w_last_nxt  = r_owner;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Address/data stay on the owner's values; s_req is low so the slave
        // treats them as don't-care. s_addr_ok is ignored here.
        w_fwd = 1'b1;
        if (s_data_ok) begin
          w_data_ok   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_fwd) begin
      s_wr    = w_sel ? data_wr    : inst_wr;
      s_size  = w_sel ? data_size  : inst_size;
      s_addr  = w_sel ? data_addr  : inst_addr;
      s_wdata = w_sel ? data_wdata : inst_wdata;
    end
  end

  // Handshakes are routed only to the granted master.
  assign inst_addr_ok = w_addr_ok & ~w_sel;
  assign data_addr_ok = w_addr_ok &  w_sel;
  assign inst_data_ok = w_data_ok & ~r_owner;
  assign data_data_ok = w_data_ok &  r_owner;

  // Read data is broadcast; each master qualifies it with its own data_ok.
  assign inst_rdata = s_rdata;
  assign data_rdata = s_rdata;

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_likesram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_likesram_arbiter
//
// Self-checking bench for likesram_arbiter. The bench plays both masters and
// the slave. Expected grants come from a transaction-level model: each master
// is either pending or not, and when both are pending the one that did not win
// the previous address handshake (m_last) is granted.
// -----------------------------------------------------------------------------
module tb_likesram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          s_req, s_wr;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          s_addr_ok, s_data_ok, busy;

  always #5 clk = ~clk;

  likesram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .busy(busy)
  );

  // Grouped views of the outputs: {inst, data} ordering for handshakes.
  logic [1:0]  aok, dok;
  logic [72:0] all_out;
  assign aok     = {inst_addr_ok, data_addr_ok};
  assign dok     = {inst_data_ok, data_data_ok};
  assign all_out = {s_req, s_wr, s_size, s_addr, s_wdata,
                    inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy};

  int total = 0;
  int bad   = 0;

  // Master model: index 0 = instruction, 1 = data.
  int            m_last;
  logic          m_req  [2];
  logic          m_wr   [2];
  logic [1:0]    m_size [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];

  function automatic logic [1:0] who(input int w);
    return (w == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic drive();
    inst_req = m_req[0]; inst_wr = m_wr[0]; inst_size = m_size[0];
    inst_addr = m_addr[0]; inst_wdata = m_wdata[0];
    data_req = m_req[1]; data_wr = m_wr[1]; data_size = m_size[1];
    data_addr = m_addr[1]; data_wdata = m_wdata[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_xact(input int m);
    m_req[m]   = 1'b1;
    m_wr[m]    = 1'($urandom_range(0, 1));
    m_size[m]  = 2'($urandom_range(0, 2));
    m_addr[m]  = $urandom;
    m_wdata[m] = $urandom;
  endtask

  task automatic clear_all();
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 1'b0; m_wr[m] = 1'b0; m_size[m] = '0; m_addr[m] = '0; m_wdata[m] = '0;
    end
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    drive();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    new_xact(0); new_xact(1);
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    drive();
    tick(); tick();
    @(negedge clk);
    if (all_out !== 73'd0) begin bad++; $display("FAIL reset_outputs: got %h exp 0", all_out); end
    total++;
    tick();
    clear_all();
    resetn = 1'b1;
    m_last = 0;
    @(negedge clk);
    if (all_out !== 73'd0) begin bad++; $display("FAIL reset_idle: got %h exp 0", all_out); end
    total++;
    tick();
  endtask

  // Both masters always requesting: data first, then strict alternation.
  task automatic test_data_first();
    int w, lat;
    new_xact(0); new_xact(1);
    for (int k = 0; k < 9; k++) begin
      w = 1 - m_last;
      s_addr_ok = 1'b1; drive();
      @(negedge clk);
      if (aok !== who(w)) begin bad++; $display("FAIL alt_addr_ok[%0d]: got %b exp %b", k, aok, who(w)); end
      total++;
      if (s_addr !== m_addr[w]) begin bad++; $display("FAIL alt_s_addr[%0d]: got %h exp %h", k, s_addr, m_addr[w]); end
      total++;
      m_last = w;
      tick();
      new_xact(w);
      s_addr_ok = 1'b0; drive();
      lat = (k == 0) ? 3 : int'($urandom_range(1, 3));
      for (int c = 1; c <= lat; c++) begin
        s_data_ok = (c == lat); s_rdata = $urandom;
        @(negedge clk);
        if ({s_req, busy, dok} !== {1'b0, 1'b1, (c == lat) ? who(w) : 2'b00}) begin
          bad++;
          $display("FAIL alt_resp[%0d.%0d]: got req/busy/dok %b%b%b exp 01%b", k, c, s_req, busy, dok,
                   (c == lat) ? who(w) : 2'b00);
        end
        total++;
        tick();
      end
      s_data_ok = 1'b0;
    end
    clear_all();
  endtask

  task automatic test_grant_lock();
    new_xact(0); m_wr[0] = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (cyc == 2) new_xact(1);
      s_addr_ok = (cyc == 5); drive();
      @(negedge clk);
      if (s_addr !== m_addr[0]) begin bad++; $display("FAIL lock_s_addr[%0d]: got %h exp %h", cyc, s_addr, m_addr[0]); end
      total++;
      if (aok !== ((cyc == 5) ? 2'b10 : 2'b00)) begin
        bad++; $display("FAIL lock_addr_ok[%0d]: got %b exp %b", cyc, aok, (cyc == 5) ? 2'b10 : 2'b00);
      end
      total++;
      tick();
    end
    m_last = 0; m_req[0] = 1'b0; s_addr_ok = 1'b0; drive();
    for (int c = 1; c <= 2; c++) begin
      s_data_ok = (c == 2); drive();
      @(negedge clk);
      if ({aok, dok} !== {2'b00, (c == 2) ? 2'b10 : 2'b00}) begin
        bad++; $display("FAIL lock_resp[%0d]: got aok/dok %b%b exp 00%b", c, aok, dok, (c == 2) ? 2'b10 : 2'b00);
      end
      total++;
      tick();
    end
    s_data_ok = 1'b0; s_addr_ok = 1'b1; drive();
    @(negedge clk);
    if (aok !== 2'b01) begin bad++; $display("FAIL lock_data_after: got %b exp 01", aok); end
    total++;
    m_last = 1;
    tick();
    m_req[1] = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; drive();
    @(negedge clk);
    if (dok !== 2'b01) begin bad++; $display("FAIL lock_data_dok: got %b exp 01", dok); end
    total++;
    tick();
    clear_all();
  endtask

  task automatic test_write();
    m_req[1] = 1'b1; m_wr[1] = 1'b1; m_size[1] = 2'd2;
    m_addr[1] = 32'hBFAF_0000; m_wdata[1] = 32'h1234_5678;
    s_addr_ok = 1'b1; drive();
    @(negedge clk);
    if ({s_req, s_wr, s_size, s_addr, s_wdata, aok} !==
        {1'b1, 1'b1, 2'd2, 32'hBFAF_0000, 32'h1234_5678, 2'b01}) begin
      bad++; $display("FAIL write_fwd: got req=%b wr=%b size=%0d addr=%h wdata=%h aok=%b exp 1 1 2 bfaf0000 12345678 01",
                      s_req, s_wr, s_size, s_addr, s_wdata, aok);
    end
    total++;
    m_last = 1;
    tick();
    m_req[1] = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; drive();
    @(negedge clk);
    if (dok !== 2'b01) begin bad++; $display("FAIL write_dok: got %b exp 01", dok); end
    total++;
    tick();
    clear_all();
  endtask

  task automatic test_read();
    new_xact(0); m_wr[0] = 1'b0;
    s_addr_ok = 1'b1; drive();
    @(negedge clk);
    if ({aok, s_wr} !== {2'b10, 1'b0}) begin bad++; $display("FAIL read_addr: got aok=%b wr=%b exp 10 0", aok, s_wr); end
    total++;
    m_last = 0;
    tick();
    m_req[0] = 1'b0; s_addr_ok = 1'b0; s_rdata = 32'h2408_0001; s_data_ok = 1'b1; drive();
    @(negedge clk);
    if ({inst_rdata, dok} !== {32'h2408_0001, 2'b10}) begin
      bad++; $display("FAIL read_data: got rdata=%h dok=%b exp 24080001 10", inst_rdata, dok);
    end
    total++;
    tick();
    clear_all();
  endtask

  task automatic test_stray();
    s_data_ok = 1'b1; s_addr_ok = 1'b1;
    @(negedge clk);
    if ({aok, dok, busy, s_req} !== 6'b0) begin
      bad++; $display("FAIL stray_idle: got aok=%b dok=%b busy=%b req=%b exp all 0", aok, dok, busy, s_req);
    end
    total++;
    tick();
    s_data_ok = 1'b0; s_addr_ok = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0) begin bad++; $display("FAIL stray_busy: got %b exp 0", busy); end
    total++;
    tick();
  endtask

  task automatic test_random();
    int w, l1, l2;
    for (int t = 0; t < 40; t++) begin
      if (!m_req[0] && !m_req[1]) begin
        int sel = int'($urandom_range(0, 2));
        if (sel != 1) new_xact(0);
        if (sel != 0) new_xact(1);
      end else begin
        for (int m = 0; m < 2; m++) if (!m_req[m] && $urandom_range(0, 1) == 1) new_xact(m);
      end
      w  = (m_req[0] && m_req[1]) ? 1 - m_last : (m_req[1] ? 1 : 0);
      l1 = int'($urandom_range(0, 2));
      for (int c = 0; c <= l1; c++) begin
        if (c > 0 && !m_req[1 - w] && $urandom_range(0, 1) == 1) new_xact(1 - w);
        s_addr_ok = (c == l1);
        s_data_ok = (c < l1) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive();
        @(negedge clk);
        if ({s_req, s_wr, s_size, s_addr, s_wdata} !== {1'b1, m_wr[w], m_size[w], m_addr[w], m_wdata[w]}) begin
          bad++; $display("FAIL rand_fwd[%0d.%0d]: got %b %b %0d %h %h exp 1 %b %0d %h %h", t, c,
                          s_req, s_wr, s_size, s_addr, s_wdata, m_wr[w], m_size[w], m_addr[w], m_wdata[w]);
        end
        total++;
        if ({aok, dok, busy} !== {(c == l1) ? who(w) : 2'b00, 2'b00, c != 0}) begin
          bad++; $display("FAIL rand_addr[%0d.%0d]: got aok=%b dok=%b busy=%b exp %b 00 %b", t, c, aok, dok, busy,
                          (c == l1) ? who(w) : 2'b00, c != 0);
        end
        total++;
        tick();
      end
      m_last = w; m_req[w] = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
      l2 = int'($urandom_range(1, 3));
      for (int c = 1; c <= l2; c++) begin
        s_addr_ok = 1'($urandom_range(0, 1));
        s_data_ok = (c == l2);
        s_rdata   = $urandom;
        drive();
        @(negedge clk);
        if ({s_req, busy, aok, dok} !== {1'b0, 1'b1, 2'b00, (c == l2) ? who(w) : 2'b00}) begin
          bad++; $display("FAIL rand_resp[%0d.%0d]: got req=%b busy=%b aok=%b dok=%b exp 0 1 00 %b", t, c,
                          s_req, busy, aok, dok, (c == l2) ? who(w) : 2'b00);
        end
        total++;
        if (c == l2 && ((w == 1) ? data_rdata : inst_rdata) !== s_rdata) begin
          bad++; $display("FAIL rand_rdata[%0d]: got %h exp %h", t, (w == 1) ? data_rdata : inst_rdata, s_rdata);
        end
        if (c == l2) total++;
        tick();
      end
      s_addr_ok = 1'b0; s_data_ok = 1'b0; drive();
    end
    clear_all();
    tick();
  endtask

  task automatic test_reset_in_resp();
    new_xact(0); m_req[1] = 1'b0; s_addr_ok = 1'b1; drive();
    tick();
    m_last = 0; m_req[0] = 1'b0; s_addr_ok = 1'b0; new_xact(1); drive();
    @(negedge clk);
    if (busy !== 1'b1) begin bad++; $display("FAIL rir_busy: got %b exp 1", busy); end
    total++;
    resetn = 1'b0; s_data_ok = 1'b1;
    #1;
    if (all_out !== 73'd0) begin bad++; $display("FAIL rir_reset_out: got %h exp 0", all_out); end
    total++;
    tick();
    clear_all();
    resetn = 1'b1; m_last = 0; s_data_ok = 1'b1;
    @(negedge clk);
    if ({dok, busy} !== 3'b000) begin bad++; $display("FAIL rir_stray: got dok=%b busy=%b exp 00 0", dok, busy); end
    total++;
    tick();
    s_data_ok = 1'b0; new_xact(0); new_xact(1); s_addr_ok = 1'b1; drive();
    @(negedge clk);
    if ({aok, s_addr} !== {2'b01, m_addr[1]}) begin
      bad++; $display("FAIL rir_tie: got aok=%b addr=%h exp 01 %h", aok, s_addr, m_addr[1]);
    end
    total++;
    m_last = 1;
    tick();
    m_req[1] = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; drive();
    @(negedge clk);
    if (dok !== 2'b01) begin bad++; $display("FAIL rir_dok: got %b exp 01", dok); end
    total++;
    tick();
    clear_all();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    clear_all();
    test_reset();
    test_data_first();
    test_grant_lock();
    test_write();
    test_read();
    test_stray();
    test_random();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
